// File: rtl/plic_claim_engine.sv
// rtl/plic_claim_engine.sv - AXI4 master running the PLIC claim/complete handshake for one hart context
module plic_claim_engine #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          ID_WIDTH   = 2,
  parameter logic [31:0] PLIC_BASE  = 32'h0,
  parameter int          CONTEXT    = 0,
  parameter int          HOLDOFF    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  irq_i,
  output logic [31:0]           id_o,
  output logic                  id_valid_o,
  input  logic                  id_ready_i,
  input  logic                  done_i,
  output logic                  busy_o,
  output logic                  err_o,
  output logic [15:0]           claim_cnt_o,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [31:0]           m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready
);

  localparam logic [31:0] CTX_OFFSET = 32'h1000 * 32'(CONTEXT);
  localparam logic [31:0] CLAIM_ADDR = PLIC_BASE + 32'h0020_0004 + CTX_OFFSET;
  localparam logic [15:0] HOLD_LOAD  = 16'(HOLDOFF);

  typedef enum logic [2:0] {
    IDLE, AR, R, PRESENT, SERVICE, WR, B, HOLD
  } state_t;

  state_t      state;
  logic [15:0] hold_cnt;
  logic [15:0] claim_cnt;
  logic        unused_inputs;

  assign m_axi_arid    = '0;
  assign m_axi_awid    = '0;
  assign m_axi_araddr  = ADDR_WIDTH'(CLAIM_ADDR);
  assign m_axi_awaddr  = ADDR_WIDTH'(CLAIM_ADDR);
  assign m_axi_arlen   = 8'd0;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_arsize  = 3'b010;
  assign m_axi_awsize  = 3'b010;
  assign m_axi_arburst = 2'b01;
  assign m_axi_awburst = 2'b01;
  assign m_axi_wdata   = id_o;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wlast   = 1'b1;
  assign claim_cnt_o   = claim_cnt;
  assign unused_inputs = ^{m_axi_rid, m_axi_rlast, m_axi_bid};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      claim_cnt     <= '0;
      id_o          <= '0;
      id_valid_o    <= 1'b0;
      busy_o        <= 1'b0;
      err_o         <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (irq_i && hold_cnt == 16'd0) begin
            state         <= AR;
            m_axi_arvalid <= 1'b1;
            busy_o        <= 1'b1;
          end
        end
        AR: begin
          if (m_axi_arready) begin
            state         <= R;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
          end
        end
        R: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            if (m_axi_rresp != 2'b00) begin
              err_o    <= 1'b1;
              hold_cnt <= HOLD_LOAD;
              state    <= HOLD;
            end else if (m_axi_rdata == 32'd0) begin
              hold_cnt <= HOLD_LOAD;
              state    <= HOLD;
            end else begin
              id_o       <= m_axi_rdata;
              id_valid_o <= 1'b1;
              if (claim_cnt != 16'hFFFF) claim_cnt <= claim_cnt + 16'd1;
              state      <= PRESENT;
            end
          end
        end
        PRESENT: begin
          if (id_ready_i) begin
            id_valid_o <= 1'b0;
            state      <= SERVICE;
          end
        end
        SERVICE: begin
          if (done_i) begin
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            state         <= WR;
          end
        end
        WR: begin
          // AW and W retire independently; move on once neither is still pending
          if (m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
          if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
            m_axi_bready <= 1'b1;
            state        <= B;
          end
        end
        B: begin
          if (m_axi_bvalid) begin
            if (m_axi_bresp != 2'b00) err_o <= 1'b1;
            m_axi_bready <= 1'b0;
            busy_o       <= 1'b0;
            state        <= IDLE;
          end
        end
        HOLD: begin
          // HOLD plus the IDLE cycle that follows it span HOLDOFF cycles before the next AR
          if (hold_cnt <= 16'd2) begin
            hold_cnt <= '0;
            busy_o   <= 1'b0;
            state    <= IDLE;
          end else begin
            hold_cnt <= hold_cnt - 16'd1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
